// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply / divide unit.
// Signed and unsigned WIDTH x WIDTH multiply (2*WIDTH-bit result on hi:lo)
// and divide (quotient on lo, remainder on hi). One bit is processed per
// cycle, so an operation takes WIDTH RUN cycles plus one FIX cycle.
// Signed operands are reduced to magnitudes on acceptance, and the sign is
// put back in FIX. A divide by zero skips the datapath entirely.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  // Iteration counter only needs to reach WIDTH-1.
  localparam int                 CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]      LAST_ITER = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
  localparam logic [WIDTH-1:0]   ONE_W     = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W    = (2*WIDTH)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  // Control state
  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_is_div;
  logic                r_neg_lo;   // negate product, or negate quotient
  logic                r_neg_hi;   // negate remainder (dividend sign)

  // Datapath state.
  // Multiply: r_acc = {partial product high, multiplier shifting out},
  //           r_opnd = multiplicand magnitude.
  // Divide:   r_acc = {partial remainder, dividend shifting out / quotient
  //           bits shifting in}, r_opnd = divisor magnitude.
  logic [WIDTH-1:0]    r_opnd;
  logic [2*WIDTH-1:0]  r_acc;

  // Registered outputs
  logic                r_busy;
  logic                r_done;
  logic                r_dbz;
  logic [WIDTH-1:0]    r_hi;
  logic [WIDTH-1:0]    r_lo;

  // Operand conditioning at acceptance. op[0]=1 means unsigned, op[1]=1
  // means divide. Negating the most-negative value wraps back to itself,
  // which read as unsigned is exactly its magnitude.
  logic                w_signed_op;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [WIDTH-1:0]    w_a_mag;
  logic [WIDTH-1:0]    w_b_mag;
  logic                w_b_zero;

  assign w_signed_op = ~op[0];
  assign w_a_neg     = w_signed_op & a[WIDTH-1];
  assign w_b_neg     = w_signed_op & b[WIDTH-1];
  assign w_a_mag     = w_a_neg ? (~a + ONE_W) : a;
  assign w_b_mag     = w_b_neg ? (~b + ONE_W) : b;
  assign w_b_zero    = (b == '0);

  // Multiply step: add multiplicand to the upper half when the multiplier
  // LSB is set, then shift the whole accumulator right by one. The carry out
  // of the add becomes the new MSB.
  logic [WIDTH:0]      w_mul_sum;
  logic [2*WIDTH-1:0]  w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide step: shift remainder left, bringing in the next
  // dividend bit, and subtract the divisor if it fits. The shifted remainder
  // needs one extra bit; the difference, when kept, is below the divisor and
  // so fits in WIDTH bits.
  logic [WIDTH:0]      w_rem_sh;
  logic                w_fits;
  logic [WIDTH-1:0]    w_trial;
  logic [2*WIDTH-1:0]  w_div_next;

  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_fits     = (w_rem_sh >= {1'b0, r_opnd});
  assign w_trial    = w_rem_sh[WIDTH-1:0] - r_opnd;
  assign w_div_next = w_fits ? {w_trial,             r_acc[WIDTH-2:0], 1'b1}
                             : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  // Sign correction applied in FIX.
  logic [2*WIDTH-1:0]  w_prod;
  logic [WIDTH-1:0]    w_quo;
  logic [WIDTH-1:0]    w_rem;

  assign w_prod = r_neg_lo ? (~r_acc + ONE_2W) : r_acc;
  assign w_quo  = r_neg_lo ? (~r_acc[WIDTH-1:0] + ONE_W) : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_hi ? (~r_acc[2*WIDTH-1:WIDTH] + ONE_W)
                           : r_acc[2*WIDTH-1:WIDTH];

  // Control FSM plus datapath and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_cnt    <= '0;
            r_is_div <= op[1];
            if (op[1] && w_b_zero) begin
              // Divide by zero: report immediately, hi/lo untouched.
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_dbz    <= 1'b0;
              r_busy   <= 1'b1;
              r_neg_lo <= w_a_neg ^ w_b_neg;
              r_neg_hi <= w_a_neg;
              r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
              r_opnd   <= op[1] ? w_b_mag : w_a_mag;
              r_state  <= S_RUN;
            end
          end
        end

        S_RUN: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == LAST_ITER) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit at WIDTH=32. Each issued operation pushes its
// expected result (from plain 64-bit arithmetic) onto a scoreboard queue,
// which is popped and compared when done is seen.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  // Directed vectors
  logic [1:0]   t_op [0:7] = '{OP_MULT, OP_MULTU, OP_DIVU, OP_DIV, OP_DIV,
                               OP_MULT, OP_DIVU, OP_DIV};
  logic [W-1:0] t_a  [0:7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd100, 32'hFFFFFFF9,
                               32'h80000000, 32'h80000000, 32'd7, 32'd7};
  logic [W-1:0] t_b  [0:7] = '{32'h00000005, 32'hFFFFFFFF, 32'd7, 32'd2,
                               32'hFFFFFFFF, 32'h80000000, 32'd100, 32'hFFFFFFFE};

  // Reference result using wide signed arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t e;
    logic signed [2*W-1:0] sx, sy, p, q, r;
    sx = o[0] ? {{W{1'b0}}, x} : {{W{x[W-1]}}, x};
    sy = o[0] ? {{W{1'b0}}, y} : {{W{y[W-1]}}, y};
    if (!o[1]) begin
      p     = sx * sy;
      e.hi  = p[2*W-1:W];
      e.lo  = p[W-1:0];
      e.dbz = 1'b0;
      e.lat = W + 2;
    end else if (y == '0) begin
      e.hi  = m_hi;
      e.lo  = m_lo;
      e.dbz = 1'b1;
      e.lat = 1;
    end else begin
      q     = sx / sy;
      r     = sx % sy;
      e.hi  = r[W-1:0];
      e.lo  = q[W-1:0];
      e.dbz = 1'b0;
      e.lat = W + 2;
    end
    return e;
  endfunction

  // Push expectation, pulse start for the accepting edge, then scramble inputs.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e = model(o, x, y);
    sb_q.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom);
    a  = $urandom;
    b  = $urandom;
  endtask

  // Count negedges after acceptance until done; lat=-1 if it never comes.
  // Optionally pulses start with other operands at cycle inject_at.
  task automatic wait_done(input int inject_at, output int lat, output int busy_cnt,
                           output bit held);
    logic [W-1:0] h0, l0;
    h0 = hi; l0 = lo;
    busy_cnt = 0; held = 1'b1; lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        busy_cnt++;
        if (hi !== h0 || lo !== l0) held = 1'b0;
      end
      if (k == inject_at) begin
        start = 1'b1; op = OP_MULTU; a = 32'h1111; b = 32'h2222;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    $display("txn: lat=%0d busy_cycles=%0d hi=%h lo=%h dbz=%b", lat, busy_cnt, hi, lo, div_by_zero);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd6;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (hi !== '0) begin n_bad++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_cmp++; if (lo !== '0) begin n_bad++; $display("FAIL reset_lo: got %h want 0", lo); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_prio_busy: got %b want 0", busy); end
  endtask

  task automatic test_directed();
    int lat, bc; bit held; exp_t e;
    for (int i = 0; i < 8; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      wait_done(0, lat, bc, held);
      e = sb_q.pop_front();
      n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, e.lat); end
      n_cmp++; if (hi !== e.hi) begin n_bad++; $display("FAIL dir%0d_hi: got %h want %h", i, hi, e.hi); end
      n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL dir%0d_lo: got %h want %h", i, lo, e.lo); end
      n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL dir%0d_dbz: got %b want 0", i, div_by_zero); end
      n_cmp++; if (bc !== W + 1) begin n_bad++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, bc, W + 1); end
      n_cmp++; if (held !== 1'b1) begin n_bad++; $display("FAIL dir%0d_hilo_hold: got %b want 1", i, held); end
    end
  endtask

  task automatic test_div_by_zero();
    int lat, bc; bit held; exp_t e;
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(0, lat, bc, held);
    e = sb_q.pop_front();
    n_cmp++; if (hi !== e.hi || lo !== e.lo) begin n_bad++; $display("FAIL dbz_pre: got %h/%h want %h/%h", hi, lo, e.hi, e.lo); end
    issue(OP_DIV, 32'd123, 32'd0);
    wait_done(0, lat, bc, held);
    e = sb_q.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL dbz_latency: got %0d want %0d", lat, e.lat); end
    n_cmp++; if (div_by_zero !== e.dbz) begin n_bad++; $display("FAIL dbz_flag: got %b want %b", div_by_zero, e.dbz); end
    n_cmp++; if (hi !== e.hi || lo !== e.lo) begin n_bad++; $display("FAIL dbz_hilo_kept: got %h/%h want %h/%h", hi, lo, e.hi, e.lo); end
    n_cmp++; if (bc !== 0) begin n_bad++; $display("FAIL dbz_busy_cycles: got %0d want 0", bc); end
    issue(OP_MULT, 32'd3, 32'hFFFFFFFC);
    wait_done(0, lat, bc, held);
    e = sb_q.pop_front();
    n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL dbz_cleared: got %b want 0", div_by_zero); end
    n_cmp++; if (hi !== e.hi || lo !== e.lo) begin n_bad++; $display("FAIL dbz_next_mult: got %h/%h want %h/%h", hi, lo, e.hi, e.lo); end
  endtask

  task automatic test_ignore_start();
    int lat, bc, n_done, n_busy; bit held; exp_t e;
    issue(OP_MULTU, 32'd12345, 32'd678);
    wait_done(5, lat, bc, held);
    e = sb_q.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL ign_latency: got %0d want %0d", lat, e.lat); end
    n_cmp++; if (hi !== e.hi || lo !== e.lo) begin n_bad++; $display("FAIL ign_result: got %h/%h want %h/%h", hi, lo, e.hi, e.lo); end
    // start held across the edge leaving DONE must also be dropped
    start = 1'b1; op = OP_MULTU; a = 32'd9; b = 32'd9;
    n_done = 0; n_busy = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) n_done++;
      if (busy === 1'b1) n_busy++;
    end
    n_cmp++; if (n_done !== 0) begin n_bad++; $display("FAIL ign_extra_done: got %0d want 0", n_done); end
    n_cmp++; if (n_busy !== 0) begin n_bad++; $display("FAIL ign_start_in_done: got %0d want 0", n_busy); end
  endtask

  task automatic test_back_to_back();
    int lat, bc; bit held; exp_t e;
    logic [1:0] o; logic [W-1:0] x, y;
    for (int i = 0; i < 20; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      case ($urandom_range(0, 5))
        0: y = '0;
        1: y = W'($urandom_range(1, 20));
        2: y = '1;
        default: y = $urandom;
      endcase
      issue(o, x, y);
      wait_done(0, lat, bc, held);
      e = sb_q.pop_front();
      n_cmp++;
      if (lat !== e.lat || hi !== e.hi || lo !== e.lo || div_by_zero !== e.dbz) begin
        n_bad++;
        $display("FAIL b2b%0d op=%0d a=%h b=%h: got lat=%0d %h/%h dbz=%b want lat=%0d %h/%h dbz=%b",
                 i, o, x, y, lat, hi, lo, div_by_zero, e.lat, e.hi, e.lo, e.dbz);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n_done;
    issue(OP_DIVU, 32'hDEADBEEF, 32'd3);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    m_hi = '0; m_lo = '0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_cmp++; if (hi !== '0 || lo !== '0) begin n_bad++; $display("FAIL rmid_hilo: got %h/%h want 0/0", hi, lo); end
    n_done = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    n_cmp++; if (n_done !== 0) begin n_bad++; $display("FAIL rmid_no_done: got %0d want 0", n_done); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    test_reset();
    test_directed();
    test_div_by_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
